// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
//   clr_state_t : clear-engine FSM states
//   bus_width() : width of a packed multi-port bus (ports * bits per port)
package regfile_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;

  function automatic int unsigned bus_width(input int unsigned ports, input int unsigned width);
    return ports * width;
  endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Sequential clear engine: walks every register index once, one per cycle.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr_req   : start a clear (only honoured in IDLE)
//   busy      : high whenever the engine is not IDLE
//   clr_done  : one-cycle pulse in the DONE state
//   clr_we    : zero register clr_idx at the next edge
//   clr_idx   : register index currently being cleared
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  clr_done,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_idx
);

  // Last index is all ones since the array depth is a power of two.
  localparam logic [ADDR_WIDTH-1:0] LastIdx = '1;

  clr_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        idx_d = idx_q + ADDR_WIDTH'(1);
        if (idx_q == LastIdx) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All outputs decode registered state only; clr_req never reaches them.
  assign busy     = (state_q != IDLE);
  assign clr_done = (state_q == DONE);
  assign clr_we   = (state_q == CLEAR);
  assign clr_idx  = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_READ async read ports, two write ports
// (port 1 wins on collision), optional hardwired zero register, optional
// write-to-read bypass and a sequential clear engine.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   wr0_en/addr/data             : write port 0
//   wr1_en/addr/data             : write port 1 (priority)
//   rd_addr / rd_data            : packed read ports, port i at [i*W +: W]
//   clr_req / busy / clr_done    : clear handshake
//   wr_reject                    : write presented while busy was dropped
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         wr0_en,
  input  logic [ADDR_WIDTH-1:0]                        wr0_addr,
  input  logic [DATA_WIDTH-1:0]                        wr0_data,
  input  logic                                         wr1_en,
  input  logic [ADDR_WIDTH-1:0]                        wr1_addr,
  input  logic [DATA_WIDTH-1:0]                        wr1_data,
  input  logic [bus_width(NUM_READ, ADDR_WIDTH)-1:0]   rd_addr,
  output logic [bus_width(NUM_READ, DATA_WIDTH)-1:0]   rd_data,
  input  logic                                         clr_req,
  output logic                                         busy,
  output logic                                         clr_done,
  output logic                                         wr_reject
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
  localparam bit          ZeroReg  = (ZERO_REG != 0);
  localparam bit          Bypass   = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic                  wr0_acc, wr1_acc;

  regfile_clr_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clr_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_idx  (clr_idx)
  );

  assign wr0_acc   = wr0_en & ~busy & ~(ZeroReg && (wr0_addr == '0));
  assign wr1_acc   = wr1_en & ~busy & ~(ZeroReg && (wr1_addr == '0));
  assign wr_reject = busy & (wr0_en | wr1_en);

  // Port 1 is written after port 0 so it wins a same-address collision.
  // No write is accepted while busy, so clear and writes never overlap.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (clr_we) begin
      mem_q[clr_idx] <= '0;
    end else begin
      if (wr0_acc) mem_q[wr0_addr] <= wr0_data;
      if (wr1_acc) mem_q[wr1_addr] <= wr1_data;
    end
  end

  for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rv;

    assign ra = rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rv = mem_q[ra];
      if (Bypass && wr0_acc && (wr0_addr == ra)) rv = wr0_data;
      if (Bypass && wr1_acc && (wr1_addr == ra)) rv = wr1_data;
      if (ZeroReg && (ra == '0)) rv = '0;
    end

    assign rd_data[g*DATA_WIDTH +: DATA_WIDTH] = rv;
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int DW   = 8;
  localparam int AW   = 3;
  localparam int NR   = 2;
  localparam int NREG = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           wr0_en, wr1_en;
  logic [AW-1:0]  wr0_addr, wr1_addr;
  logic [DW-1:0]  wr0_data, wr1_data;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic           clr_req, busy, clr_done, wr_reject;

  regfile_mp #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_READ   (NR),
    .ZERO_REG   (1),
    .BYPASS     (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr0_en    (wr0_en),
    .wr0_addr  (wr0_addr),
    .wr0_data  (wr0_data),
    .wr1_en    (wr1_en),
    .wr1_addr  (wr1_addr),
    .wr1_data  (wr1_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .clr_req   (clr_req),
    .busy      (busy),
    .clr_done  (clr_done),
    .wr_reject (wr_reject)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: register contents plus the edge number at which the
  // last clear was launched. Clear progress is derived from elapsed edges.
  logic [DW-1:0] mem_m [NREG];
  int cyc   = 0;
  int clr_k = -1;
  int busy_cnt, done_cnt;

  function automatic logic m_busy();
    return (clr_k >= 0) && ((cyc - clr_k) <= NREG);
  endfunction

  function automatic logic m_done();
    return (clr_k >= 0) && ((cyc - clr_k) == NREG);
  endfunction

  function automatic logic [DW-1:0] m_read(input int a);
    if (a == 0) return '0;
    if (!m_busy()) begin
      if (wr1_en && int'(wr1_addr) == a) return wr1_data;
      if (wr0_en && int'(wr0_addr) == a) return wr0_data;
    end
    return mem_m[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("busy", 32'(busy), 32'(m_busy()));
    chk("clr_done", 32'(clr_done), 32'(m_done()));
    chk("wr_reject", 32'(wr_reject), 32'(m_busy() && (wr0_en || wr1_en)));
    chk("rd0", 32'(rd_data[0 +: DW]), 32'(m_read(int'(rd_addr[0 +: AW]))));
    chk("rd1", 32'(rd_data[DW +: DW]), 32'(m_read(int'(rd_addr[AW +: AW]))));
  endtask

  // Model state advance for the edge about to happen.
  task automatic commit();
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem_m[i] = '0;
      clr_k = -1;
    end else if (m_busy()) begin
      if ((cyc - clr_k) < NREG) mem_m[cyc - clr_k] = '0;
    end else begin
      if (wr0_en && wr0_addr != 0) mem_m[wr0_addr] = wr0_data;
      if (wr1_en && wr1_addr != 0) mem_m[wr1_addr] = wr1_data;
      if (clr_req) clr_k = cyc + 1;
    end
    cyc++;
  endtask

  // One clock: settle, check outputs against the model, take the edge.
  task automatic cycle();
    #2;
    check_all();
    if (busy === 1'b1) busy_cnt++;
    if (clr_done === 1'b1) done_cnt++;
    commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wr0_en = 0; wr1_en = 0; clr_req = 0;
    wr0_addr = '0; wr1_addr = '0; wr0_data = '0; wr1_data = '0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic fill();
    for (int i = 1; i < NREG; i++) begin
      wr0_en = 1; wr0_addr = AW'(i); wr0_data = DW'(i * 8'h11);
      cycle();
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    rst = 1;
    set_rd(0, 0);
    for (int i = 0; i < NREG; i++) mem_m[i] = 8'hXX;
    cycle();
    cycle();
    rst = 0;

    // Reset state: every address reads zero on both ports.
    for (int a = 0; a < NREG; a++) begin
      set_rd(a, NREG - 1 - a);
      cycle();
    end

    // Same-address collision: port 1 wins, visible same cycle via bypass.
    wr0_en = 1; wr0_addr = 3; wr0_data = 8'hA5;
    wr1_en = 1; wr1_addr = 3; wr1_data = 8'h5A;
    set_rd(3, 3);
    #2 chk("collide_bypass", 32'(rd_data[0 +: DW]), 32'h5A);
    cycle();
    idle_in();
    #2 chk("collide_stored", 32'(rd_data[DW +: DW]), 32'h5A);
    cycle();

    // Write to r0 is dropped without rejection.
    wr0_en = 1; wr0_addr = 0; wr0_data = 8'hFF;
    set_rd(0, 0);
    #2 chk("r0_same", 32'(rd_data[0 +: DW]), 32'h0);
    chk("r0_no_reject", 32'(wr_reject), 32'h0);
    cycle();
    idle_in();
    #2 chk("r0_next", 32'(rd_data[0 +: DW]), 32'h0);
    cycle();

    // Full clear with a rejected write in the middle.
    fill();
    clr_req = 1;
    set_rd(1, 7);
    cycle();
    clr_req = 0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int j = 0; j < 12; j++) begin
      idle_in();
      set_rd($urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1));
      if (j == 2) begin
        wr0_en = 1; wr0_addr = 6; wr0_data = 8'h99;
        #2 chk("busy_reject", 32'(wr_reject), 32'h1);
      end
      if (j == 3) begin
        set_rd(2, 5);
        #2 chk("mid_r2", 32'(rd_data[0 +: DW]), 32'h0);
        chk("mid_r5", 32'(rd_data[DW +: DW]), 32'h55);
      end
      cycle();
    end
    chk("busy_cycles", 32'(busy_cnt), 32'(NREG + 1));
    chk("done_pulses", 32'(done_cnt), 32'h1);
    idle_in();
    for (int a = 0; a < NREG; a++) begin
      set_rd(a, a);
      #2 chk("after_clear", 32'(rd_data[0 +: DW]), 32'h0);
      cycle();
    end

    // Randomized traffic with occasional clears and collisions.
    for (int n = 0; n < 300; n++) begin
      wr0_en   = 1'($urandom_range(0, 1));
      wr1_en   = 1'($urandom_range(0, 1));
      wr0_addr = AW'($urandom);
      wr1_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : AW'($urandom);
      wr0_data = DW'($urandom);
      wr1_data = DW'($urandom);
      clr_req  = ($urandom_range(0, 39) == 0);
      set_rd($urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1));
      cycle();
    end
    idle_in();
    for (int n = 0; n < NREG + 2; n++) cycle();

    // Reset during the 4th CLEAR cycle.
    fill();
    clr_req = 1;
    cycle();
    clr_req = 0;
    for (int j = 0; j < 3; j++) cycle();
    done_cnt = 0;
    rst = 1;
    cycle();
    rst = 0;
    #2 chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(clr_done), 32'h0);
    for (int a = 0; a < NREG; a++) begin
      set_rd(a, (a + 4) % NREG);
      #2 chk("rst_zero", 32'(rd_data[0 +: DW]), 32'h0);
      cycle();
    end
    chk("rst_no_done", 32'(done_cnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file, the next-generation successor to the 8×8 two-read/one-write register file in the LegV8 datapath. It adds:
- configurable width, depth and read-port count;
- a second write port with fixed priority;
- optional write-to-read bypass;
- a sequential clear engine that zeroes the array one entry per cycle under a busy handshake.

It sits between decode (read addresses) and writeback (two retire lanes).

## Interface
Parameters:
- DATA_WIDTH, 8, bits per register
- ADDR_WIDTH, 3, address bits; NUM_REGS = 2**ADDR_WIDTH
- NUM_READ, 2, number of asynchronous read ports (1..8)
- ZERO_REG, 1, when 1 register 0 is hardwired to zero
- BYPASS, 1, when 1 a same-cycle accepted write is forwarded to matching reads

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- wr0_en  in  1  write port 0 enable
- wr0_addr  in  ADDR_WIDTH  write port 0 address
- wr0_data  in  DATA_WIDTH  write port 0 data
- wr1_en  in  1  write port 1 enable (priority over port 0)
- wr1_addr  in  ADDR_WIDTH  write port 1 address
- wr1_data  in  DATA_WIDTH  write port 1 data
- rd_addr  in  NUM_READ*ADDR_WIDTH  packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  NUM_READ*DATA_WIDTH  packed read data, same packing
- clr_req  in  1  request full-array clear
- busy  out  1  clear in progress; writes rejected
- clr_done  out  1  one-cycle pulse when the clear completes
- wr_reject  out  1  a write was presented while busy and was dropped

## Operation
- Reset: all registers 0, FSM IDLE, clear index 0, busy=0, clr_done=0. The reset-time value of wr_reject is 0.
- Write acceptance: a write is accepted when wrN_en=1, busy=0, and not (ZERO_REG=1 and wrN_addr=0). An accepted write updates the register at the next edge.
- Write collision: if both ports write the same address in one cycle, port 1 data is stored and port 0 is silently discarded.
- Read: combinational from the array.
  - ZERO_REG=1 and address 0: returns 0.
  - BYPASS=1 and the address matches an accepted write this cycle: returns that write's data (port 1 wins if both match).
  - Otherwise: returns the stored value.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE→CLEAR on clr_req=1; index←0.
  - CLEAR: zero register[index] each cycle and increment index. After index NUM_REGS-1 go to DONE. All NUM_REGS indices are stepped even when ZERO_REG=1.
  - DONE: clr_done=1 for exactly one cycle, then IDLE.
  - clr_req is ignored outside IDLE. Holding clr_req high through DONE starts a new clear on the cycle after returning to IDLE.
- busy = (state != IDLE). wr_reject = busy & (wr0_en | wr1_en), combinational.
- Reads during a clear are legal and return the partially cleared array: entries with index below the current clear index are 0; higher entries keep their old values. Bypass never fires while busy because no write is accepted.
- rst asserted mid-clear: next edge returns to IDLE with the array zeroed.

## Timing
- Write-to-read latency: 1 cycle through the array, 0 cycles through bypass.
- Clear latency: clr_req high at edge k gives busy=1 after edge k. Register i is zero after edge k+1+i. clr_done is high in the cycle after edge k+NUM_REGS. busy falls after edge k+NUM_REGS+1. Total busy time is NUM_REGS+1 cycles.
- No combinational path from clr_req to any output. The only combinational outputs are rd_data and wr_reject.

## Structure
- Package regfile_pkg holds:
  - enum clr_state_t {IDLE, CLEAR, DONE};
  - the derived-width function for the packed buses.
- One natural sub-module, regfile_clr_fsm: owns state, index, busy and clr_done, and outputs clr_we plus clr_idx to the array write logic. The array, write arbitration and read muxes stay in the top module.

## Test plan
- Reset then read all addresses on both ports: all return 0x00; busy=0.
- Write 0xA5 to r3 via port 0 and 0x5A to r3 via port 1 in the same cycle: the next read of r3 returns 0x5A. With BYPASS=1, rd_data shows 0x5A in the same cycle.
- With ZERO_REG=1, write 0xFF to r0: read r0 returns 0x00 in the same and following cycles; wr_reject=0.
- Fill r1..r7 with 0x11..0x77, pulse clr_req:
  - busy high 9 cycles;
  - mid-clear read shows r0..r2=0 while r5 is still 0x55;
  - clr_done pulses once;
  - all registers end at 0.
- Write during busy: wr_reject=1 and the register is unchanged after the clear.
- Assert rst at the 4th CLEAR cycle: the next cycle shows IDLE, busy=0, all registers 0, and no clr_done pulse.
